chk_err_log: RTL and testbench

Error-event logger downstream of the `chk` assertion checkers. It accepts one-cycle error pulses tagged with an error code and records them in a small FIFO, with optional capture-cycle timestamps. It also keeps saturating total and dropped counts and raises a sticky stop request once a configurable error threshold is reached. The testbench drains logged events over a valid/ready port.

---
 rtl/chk_pkg.sv | 16 +
 rtl/chk_err_fifo.sv | 66 ++++++
 rtl/chk_err_log.sv | 125 ++++++++++++
 tb/tb_chk_err_log.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// Shared types and error codes for the chk checker family.
package chk_pkg;

  typedef logic [7:0] err_code_t;

  localparam err_code_t ERR_NOT_ASSERTED = 8'h01;
  localparam err_code_t ERR_HAS_X        = 8'h02;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } log_state_e;

  localparam int unsigned CYC_W = 32;

endpackage

// File: rtl/chk_err_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from storage registers.
module chk_err_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/chk_err_log.sv
// Error-event logger: FIFO of error codes, saturating counters and a sticky stop request.
// Optional capture timestamps are enabled by defining CHK_ERR_LOG_TIMESTAMP_EN.
module chk_err_log
  import chk_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CODE_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STOP_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              err_valid,
  input  logic [CODE_W-1:0] err_code,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CYC_W-1:0]  out_cyc,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  dropped,
  output logic              stop_req
);

`ifdef CHK_ERR_LOG_TIMESTAMP_EN
  localparam int unsigned FIFO_W = CODE_W + CYC_W;
`else
  localparam int unsigned FIFO_W = CODE_W;
`endif

  log_state_e        state_q, state_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic              push_ok;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_head;

  assign pop = out_ready && !fifo_empty;

  // Event accounting; clr wins over a coinciding event and pop.
  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    dropped_d   = dropped_q;
    push_ok     = 1'b0;
    if (clr) begin
      state_d     = RUN;
      err_count_d = '0;
      dropped_d   = '0;
    end else if (err_valid) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      if ((state_q == RUN) && (!fifo_full || pop)) begin
        push_ok = 1'b1;
      end else if (dropped_q != '1) begin
        dropped_d = dropped_q + CNT_W'(1);
      end
      if ((state_q == RUN) && (STOP_THRESH != 0) &&
          (32'(err_count_d) == 32'(STOP_THRESH))) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= RUN;
      err_count_q <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      dropped_q   <= dropped_d;
    end
  end

`ifdef CHK_ERR_LOG_TIMESTAMP_EN
  logic [CYC_W-1:0] cyc_q, cyc_d;

  // Free-running capture cycle counter, untouched by clr.
  always_comb begin
    cyc_d = cyc_q + CYC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign fifo_din = {cyc_q, err_code};
  assign out_cyc  = fifo_head[FIFO_W-1:CODE_W];
`else
  assign fifo_din = err_code;
  assign out_cyc  = '0;
`endif

  chk_err_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .flush   (clr),
    .push    (push_ok),
    .pop     (pop),
    .din     (fifo_din),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_code  = fifo_head[CODE_W-1:0];
  assign err_count = err_count_q;
  assign dropped   = dropped_q;
  assign stop_req  = (state_q == HALT);

endmodule

// File: tb/tb_chk_err_log.sv
// Self-checking bench for chk_err_log: four configurations share one stimulus stream.
module tb_chk_err_log;

  localparam int unsigned D = 4;
  localparam int unsigned M_TH  [4] = '{1, 2, 0, 0};
  localparam int unsigned M_MAX [4] = '{65535, 65535, 65535, 3};
`ifdef CHK_ERR_LOG_TIMESTAMP_EN
  localparam logic [31:0] TS_MASK = '1;
`else
  localparam logic [31:0] TS_MASK = '0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        err_valid = 1'b0;
  logic [7:0]  err_code = 8'h00;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        ov   [4];
  logic [7:0]  oc   [4];
  logic [31:0] ocyc [4];
  logic [15:0] cnt  [4];
  logic [15:0] drop [4];
  logic        stop [4];
  logic [1:0]  sat_cnt, sat_drop;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain circular buffer plus counters per configuration.
  logic [7:0]  m_code  [4][D];
  logic [31:0] m_ts    [4][D];
  int unsigned m_head  [4];
  int unsigned m_items [4];
  int unsigned m_cnt   [4];
  int unsigned m_drop  [4];
  bit          m_halt  [4];
  logic [31:0] m_cyc;

  always #5 clk = ~clk;

  chk_err_log #(.DEPTH(D), .CODE_W(8), .CNT_W(16), .STOP_THRESH(1)) u_th1 (
    .clk(clk), .rst_l(rst_l), .err_valid(err_valid), .err_code(err_code), .clr(clr),
    .out_valid(ov[0]), .out_ready(out_ready), .out_code(oc[0]), .out_cyc(ocyc[0]),
    .err_count(cnt[0]), .dropped(drop[0]), .stop_req(stop[0]));

  chk_err_log #(.DEPTH(D), .CODE_W(8), .CNT_W(16), .STOP_THRESH(2)) u_th2 (
    .clk(clk), .rst_l(rst_l), .err_valid(err_valid), .err_code(err_code), .clr(clr),
    .out_valid(ov[1]), .out_ready(out_ready), .out_code(oc[1]), .out_cyc(ocyc[1]),
    .err_count(cnt[1]), .dropped(drop[1]), .stop_req(stop[1]));

  chk_err_log #(.DEPTH(D), .CODE_W(8), .CNT_W(16), .STOP_THRESH(0)) u_th0 (
    .clk(clk), .rst_l(rst_l), .err_valid(err_valid), .err_code(err_code), .clr(clr),
    .out_valid(ov[2]), .out_ready(out_ready), .out_code(oc[2]), .out_cyc(ocyc[2]),
    .err_count(cnt[2]), .dropped(drop[2]), .stop_req(stop[2]));

  chk_err_log #(.DEPTH(D), .CODE_W(8), .CNT_W(2), .STOP_THRESH(0)) u_sat (
    .clk(clk), .rst_l(rst_l), .err_valid(err_valid), .err_code(err_code), .clr(clr),
    .out_valid(ov[3]), .out_ready(out_ready), .out_code(oc[3]), .out_cyc(ocyc[3]),
    .err_count(sat_cnt), .dropped(sat_drop), .stop_req(stop[3]));

  assign cnt[3]  = {14'd0, sat_cnt};
  assign drop[3] = {14'd0, sat_drop};

  function automatic logic [31:0] ts_exp(input logic [31:0] t);
    return t & TS_MASK;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_head[i] = 0; m_items[i] = 0; m_cnt[i] = 0; m_drop[i] = 0; m_halt[i] = 1'b0;
    end
    m_cyc = 32'd0;
  endtask

  task automatic model_step(input int i);
    bit pop;
    pop = (m_items[i] > 0) && out_ready;
    if (clr) begin
      m_head[i] = 0; m_items[i] = 0; m_cnt[i] = 0; m_drop[i] = 0; m_halt[i] = 1'b0;
      return;
    end
    if (pop) begin
      m_head[i]  = (m_head[i] + 1) % D;
      m_items[i] = m_items[i] - 1;
    end
    if (err_valid) begin
      if (m_cnt[i] < M_MAX[i]) m_cnt[i] = m_cnt[i] + 1;
      if (!m_halt[i] && m_items[i] < D) begin
        m_code[i][(m_head[i] + m_items[i]) % D] = err_code;
        m_ts[i][(m_head[i] + m_items[i]) % D]   = m_cyc;
        m_items[i] = m_items[i] + 1;
      end else if (m_drop[i] < M_MAX[i]) begin
        m_drop[i] = m_drop[i] + 1;
      end
      if (!m_halt[i] && M_TH[i] != 0 && m_cnt[i] == M_TH[i]) m_halt[i] = 1'b1;
    end
  endtask

  // Advance model and DUT one clock edge; returns 1 time unit after the edge.
  task automatic tick();
    for (int i = 0; i < 4; i++) model_step(i);
    m_cyc = m_cyc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ov[i], oc[i], ocyc[i], cnt[i], drop[i], stop[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_vals[%0d] got v=%0b code=%0h cyc=%0h cnt=%0h drop=%0h stop=%0b exp all 0",
                 i, ov[i], oc[i], ocyc[i], cnt[i], drop[i], stop[i]);
      end
    end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    m_cyc = 32'd1;
  endtask

  task automatic test_single_event();
    out_ready = 1'b1;
    while (m_cyc != 32'd5) tick();
    err_valid = 1'b1; err_code = 8'h01;
    tick();
    err_valid = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b1 || oc[0] !== 8'h01 || ocyc[0] !== ts_exp(32'd5)) begin
      n_err++;
      $display("FAIL single_head got v=%0b code=%0h cyc=%0d exp v=1 code=01 cyc=%0d",
               ov[0], oc[0], ocyc[0], ts_exp(32'd5));
    end
    n_cmp++;
    if (cnt[0] !== 16'd1 || stop[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_cnt_stop got cnt=%0d stop=%0b exp cnt=1 stop=1", cnt[0], stop[0]);
    end
    tick();
    n_cmp++;
    if (ov[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single_popped got v=%0b exp 0", ov[0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] c [6];
    clr = 1'b1; tick(); clr = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c[k] = 8'($urandom);
      err_valid = 1'b1; err_code = c[k];
      tick();
    end
    err_valid = 1'b0;
    n_cmp++;
    if (cnt[2] !== 16'd6 || drop[2] !== 16'd2 || stop[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_counts got cnt=%0d drop=%0d stop=%0b exp cnt=6 drop=2 stop=0",
               cnt[2], drop[2], stop[2]);
    end
    n_cmp++;
    if (cnt[3] !== 16'd3 || drop[3] !== 16'd2) begin
      n_err++;
      $display("FAIL sat_counts got cnt=%0d drop=%0d exp cnt=3 drop=2", cnt[3], drop[3]);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ov[2] !== 1'b1 || oc[2] !== c[k]) begin
        n_err++;
        $display("FAIL ovf_drain%0d got v=%0b code=%0h exp v=1 code=%0h", k, ov[2], oc[2], c[k]);
      end
      tick();
    end
    n_cmp++;
    if (ov[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty got v=%0b exp 0", ov[2]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] c [6];
    clr = 1'b1; tick(); clr = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c[k] = 8'($urandom);
      err_valid = 1'b1; err_code = c[k];
      tick();
    end
    c[4] = 8'($urandom); c[5] = 8'($urandom);
    err_valid = 1'b1; err_code = c[4]; out_ready = 1'b1;
    tick();
    n_cmp++;
    if (drop[2] !== 16'd0 || cnt[2] !== 16'd5 || oc[2] !== c[1]) begin
      n_err++;
      $display("FAIL full_pushpop got drop=%0d cnt=%0d code=%0h exp drop=0 cnt=5 code=%0h",
               drop[2], cnt[2], oc[2], c[1]);
    end
    err_code = c[5]; out_ready = 1'b0;
    tick();
    err_valid = 1'b0;
    n_cmp++;
    if (drop[2] !== 16'd1 || ov[2] !== 1'b1 || oc[2] !== c[1]) begin
      n_err++;
      $display("FAIL still_full got drop=%0d v=%0b code=%0h exp drop=1 v=1 code=%0h",
               drop[2], ov[2], oc[2], c[1]);
    end
  endtask

  task automatic test_halt_clear();
    clr = 1'b1; tick(); clr = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      err_valid = 1'b1; err_code = 8'(k);
      tick();
      if (k == 2) begin
        n_cmp++;
        if (stop[1] !== 1'b1 || cnt[1] !== 16'd2 || drop[1] !== 16'd0) begin
          n_err++;
          $display("FAIL halt_enter got stop=%0b cnt=%0d drop=%0d exp stop=1 cnt=2 drop=0",
                   stop[1], cnt[1], drop[1]);
        end
      end
    end
    n_cmp++;
    if (stop[1] !== 1'b1 || cnt[1] !== 16'd3 || drop[1] !== 16'd1 || oc[1] !== 8'd1) begin
      n_err++;
      $display("FAIL halt_freeze got stop=%0b cnt=%0d drop=%0d code=%0h exp stop=1 cnt=3 drop=1 code=1",
               stop[1], cnt[1], drop[1], oc[1]);
    end
    clr = 1'b1; err_code = 8'h44; out_ready = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (stop[i] !== 1'b0 || cnt[i] !== 16'd0 || drop[i] !== 16'd0 || ov[i] !== 1'b0) begin
        n_err++;
        $display("FAIL clr[%0d] got stop=%0b cnt=%0d drop=%0d v=%0b exp all 0",
                 i, stop[i], cnt[i], drop[i], ov[i]);
      end
    end
    out_ready = 1'b0; err_code = 8'h55;
    tick();
    err_valid = 1'b0;
    n_cmp++;
    if (stop[1] !== 1'b0 || cnt[1] !== 16'd1 || ov[1] !== 1'b1 || oc[1] !== 8'h55) begin
      n_err++;
      $display("FAIL after_clr got stop=%0b cnt=%0d v=%0b code=%0h exp stop=0 cnt=1 v=1 code=55",
               stop[1], cnt[1], ov[1], oc[1]);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      err_valid = 1'b1; err_code = 8'($urandom_range(1, 255));
      tick();
    end
    err_valid = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ov[i], oc[i], ocyc[i], cnt[i], drop[i], stop[i]} !== '0) begin
        n_err++;
        $display("FAIL async_rst[%0d] got v=%0b code=%0h cyc=%0h cnt=%0h drop=%0h stop=%0b exp all 0",
                 i, ov[i], oc[i], ocyc[i], cnt[i], drop[i], stop[i]);
      end
    end
    model_reset();
    #2;
    rst_l = 1'b1;
    err_valid = 1'b1; err_code = 8'h02;
    tick();
    err_valid = 1'b0;
    n_cmp++;
    if (ov[2] !== 1'b1 || oc[2] !== 8'h02 || ocyc[2] !== ts_exp(32'd0) || cnt[2] !== 16'd1) begin
      n_err++;
      $display("FAIL post_rst got v=%0b code=%0h cyc=%0d cnt=%0d exp v=1 code=02 cyc=%0d cnt=1",
               ov[2], oc[2], ocyc[2], cnt[2], ts_exp(32'd0));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      err_valid = ($urandom_range(0, 99) < 55);
      err_code  = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 45);
      clr       = ($urandom_range(0, 99) < 3);
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ov[i] !== (m_items[i] > 0) || stop[i] !== m_halt[i]) begin
          n_err++;
          $display("FAIL rnd_flags[%0d] n=%0d got v=%0b stop=%0b exp v=%0b stop=%0b",
                   i, n, ov[i], stop[i], (m_items[i] > 0), m_halt[i]);
        end
        n_cmp++;
        if (cnt[i] !== 16'(m_cnt[i]) || drop[i] !== 16'(m_drop[i])) begin
          n_err++;
          $display("FAIL rnd_counts[%0d] n=%0d got cnt=%0d drop=%0d exp cnt=%0d drop=%0d",
                   i, n, cnt[i], drop[i], m_cnt[i], m_drop[i]);
        end
        if (m_items[i] > 0) begin
          n_cmp++;
          if (oc[i] !== m_code[i][m_head[i]] || ocyc[i] !== ts_exp(m_ts[i][m_head[i]])) begin
            n_err++;
            $display("FAIL rnd_head[%0d] n=%0d got code=%0h cyc=%0d exp code=%0h cyc=%0d",
                     i, n, oc[i], ocyc[i], m_code[i][m_head[i]], ts_exp(m_ts[i][m_head[i]]));
          end
        end
      end
    end
    err_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_halt_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
